// File: rtl/cfg_pkg.sv
// Shared parameters and state encoding for the configuration latch-bank loader.
package cfg_pkg;
    localparam int WORD_W         = 32;
    localparam int NUM_WORDS      = 11;
    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = WORD_W / BYTE_W;
    localparam int BCNT_W         = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam int WCNT_W         = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_DONE
    } cfg_ld_state_t;
endpackage

// File: rtl/cfg_byte_packer.sv
// Packs the incoming byte stream into words, first byte in the least significant lane.
module cfg_byte_packer
    import cfg_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              accept,
    input  logic [BYTE_W-1:0] data,
    output logic [WORD_W-1:0] word,
    output logic              word_full
);
    logic [WORD_W-1:0] pack_q;
    logic [BCNT_W-1:0] byte_cnt_q;
    logic              last_byte;

    // The current byte is merged combinationally so the loader can capture the
    // complete word on the same edge that accepts its last byte.
    always_comb begin
        word = pack_q;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (byte_cnt_q == BCNT_W'(i)) begin
                word[i*BYTE_W +: BYTE_W] = data;
            end
        end
    end

    assign last_byte = (byte_cnt_q == BCNT_W'(BYTES_PER_WORD - 1));
    assign word_full = accept & last_byte;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            pack_q     <= '0;
            byte_cnt_q <= '0;
        end else if (accept) begin
            pack_q     <= word;
            byte_cnt_q <= last_byte ? '0 : byte_cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/configs_loader.sv
// Write-side driver for the configuration latch bank: packs bytes into words and
// strobes one latch enable per word with a full cycle of data setup and hold.
//
// state   | meaning
// IDLE    | waiting for io_start after reset
// COLLECT | accepting bytes until a word is complete
// SETUP   | io_d_out settled, enables low
// STROBE  | one-hot enable for word_cnt high
// HOLD    | enables low, io_d_out still held
// DONE    | all words written, waiting for a restart
module configs_loader
    import cfg_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 io_start,
    input  logic                 io_in_valid,
    output logic                 io_in_ready,
    input  logic [BYTE_W-1:0]    io_in_data,
    output logic [WORD_W-1:0]    io_d_out,
    output logic [NUM_WORDS-1:0] io_configs_en,
    output logic                 io_busy,
    output logic                 io_done
);
    cfg_ld_state_t        state_q, state_d;
    logic [WCNT_W-1:0]    word_cnt_q, word_cnt_d;
    logic [WORD_W-1:0]    d_out_q, d_out_d;
    logic [NUM_WORDS-1:0] en_q, en_d;
    logic                 pk_clear;
    logic                 accept;
    logic [WORD_W-1:0]    pk_word;
    logic                 pk_word_full;
    logic                 last_word;

    assign accept    = io_in_valid & (state_q == ST_COLLECT);
    assign last_word = (word_cnt_q == WCNT_W'(NUM_WORDS - 1));

    cfg_byte_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (pk_clear),
        .accept    (accept),
        .data      (io_in_data),
        .word      (pk_word),
        .word_full (pk_word_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            word_cnt_q <= '0;
            d_out_q    <= '0;
            en_q       <= '0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            d_out_q    <= d_out_d;
            en_q       <= en_d;
        end
    end

    // Enable is registered from the SETUP decision so it is high exactly during STROBE.
    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        d_out_d    = d_out_q;
        en_d       = '0;
        pk_clear   = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (io_start) begin
                    state_d    = ST_COLLECT;
                    word_cnt_d = '0;
                    pk_clear   = 1'b1;
                end
            end
            ST_COLLECT: begin
                if (pk_word_full) begin
                    state_d = ST_SETUP;
                    d_out_d = pk_word;
                end
            end
            ST_SETUP: begin
                state_d = ST_STROBE;
                en_d    = NUM_WORDS'(1) << word_cnt_q;
            end
            ST_STROBE: begin
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (last_word) begin
                    state_d = ST_DONE;
                end else begin
                    word_cnt_d = word_cnt_q + 1'b1;
                    state_d    = ST_COLLECT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign io_d_out      = d_out_q;
    assign io_configs_en = en_q;
    assign io_in_ready   = (state_q == ST_COLLECT);
    assign io_busy       = (state_q == ST_COLLECT) || (state_q == ST_SETUP) ||
                           (state_q == ST_STROBE)  || (state_q == ST_HOLD);
    assign io_done       = (state_q == ST_DONE);
endmodule
